// File: rtl/match_log_pkg.sv
// Shared event codes and sizes for match_event_logger and its event FIFO.
package match_log_pkg;

    typedef enum logic [1:0] {
        EVT_VOLVO = 2'd0,
        EVT_VOOL  = 2'd1,
        EVT_LOL   = 2'd2,
        EVT_OOLVO = 2'd3
    } evt_code_t;

    localparam int unsigned NUM_PATTERNS = 4;
    localparam int unsigned CODE_W       = 2;

endpackage

// File: rtl/match_log_fifo.sv
// First-word-fall-through event FIFO with wrap-bit pointers and synchronous flush.
module match_log_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !clear) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/match_event_logger.sv
// Logs rising edges of detector flags as {code, timestamp} records with per-pattern counters.
// Define MATCH_LOG_TS_EN to store a timestamp per record; otherwise evt_ts is tied to 0.
module match_event_logger #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TS_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             volvo,
    input  logic             vool,
    input  logic             lol,
    input  logic             oolvo,
    input  logic             clear,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_code,
    output logic [TS_W-1:0]  evt_ts,
    output logic [CNT_W-1:0] cnt_volvo,
    output logic [CNT_W-1:0] cnt_vool,
    output logic [CNT_W-1:0] cnt_lol,
    output logic [CNT_W-1:0] cnt_oolvo,
    output logic             overflow
);

    import match_log_pkg::*;

    logic [NUM_PATTERNS-1:0] s_q;
    logic [NUM_PATTERNS-1:0] p_q;
    logic [NUM_PATTERNS-1:0] rise;
    evt_code_t               win_code;
    logic                    hit;
    logic                    pop;
    logic                    full;
    logic                    empty;
    logic [CNT_W-1:0]        cnt [NUM_PATTERNS];

`ifdef MATCH_LOG_TS_EN
    localparam int unsigned REC_W = CODE_W + TS_W;
    logic [TS_W-1:0] ts_q;
    logic [TS_W-1:0] ts_next;
`else
    localparam int unsigned REC_W = CODE_W;
`endif

    logic [REC_W-1:0] push_rec;
    logic [REC_W-1:0] head;

    // Sampling keeps running through clear so a held flag cannot re-trigger afterwards.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s_q <= '0;
            p_q <= '0;
        end else begin
            s_q <= {oolvo, lol, vool, volvo};
            p_q <= s_q;
        end
    end

    assign rise = s_q & ~p_q;
    assign hit  = |rise;

    always_comb begin
        win_code = EVT_VOLVO;
        if (rise[0])      win_code = EVT_VOLVO;
        else if (rise[1]) win_code = EVT_VOOL;
        else if (rise[2]) win_code = EVT_LOL;
        else if (rise[3]) win_code = EVT_OOLVO;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_PATTERNS; i++) cnt[i] <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            for (int unsigned i = 0; i < NUM_PATTERNS; i++) cnt[i] <= '0;
            overflow <= 1'b0;
        end else begin
            if (hit && cnt[win_code] != '1) cnt[win_code] <= cnt[win_code] + CNT_W'(1);
            if (hit && full && !pop) overflow <= 1'b1;
        end
    end

    assign cnt_volvo = cnt[0];
    assign cnt_vool  = cnt[1];
    assign cnt_lol   = cnt[2];
    assign cnt_oolvo = cnt[3];

`ifdef MATCH_LOG_TS_EN
    // A record carries the timestamp value that the counter takes on its push edge.
    assign ts_next  = ts_q + TS_W'(1);
    assign push_rec = {win_code, ts_next};

    always_ff @(posedge clock or posedge reset) begin
        if (reset)      ts_q <= '0;
        else if (clear) ts_q <= '0;
        else            ts_q <= ts_next;
    end

    assign evt_ts = empty ? '0 : head[TS_W-1:0];
`else
    assign push_rec = win_code;
    assign evt_ts   = '0;
`endif

    assign evt_valid = !empty;
    assign pop       = evt_valid && evt_ready;
    assign evt_code  = empty ? '0 : head[REC_W-1 -: CODE_W];

    match_log_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .push  (hit),
        .pop   (pop),
        .din   (push_rec),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

endmodule
